// File: rtl/aes_encrypt_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_encrypt_if
//  Description : Request/result bundle for the iterative AES-128 encryptor.
//                The master drives the request, key and plaintext; the slave
//                returns the completion flag and the ciphertext.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_encrypt_if;
   logic         AES_START;
   logic         AES_DONE;
   logic [127:0] AES_KEY;
   logic [127:0] AES_MSG_DEC;
   logic [127:0] AES_MSG_ENC;

   modport master (
      output AES_START,
      output AES_KEY,
      output AES_MSG_DEC,
      input  AES_DONE,
      input  AES_MSG_ENC
   );

   modport slave (
      input  AES_START,
      input  AES_KEY,
      input  AES_MSG_DEC,
      output AES_DONE,
      output AES_MSG_ENC
   );
endinterface
`default_nettype wire

// File: rtl/aes_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : aes_encrypt
//  Description : Iterative AES-128 encryptor. One state register and one
//                round-key register; round keys are expanded on the fly.
//                Each of rounds 1..9 takes 7 cycles (SUB, SHIFT, 4x MIX, ARK),
//                round 10 skips MixColumns, for 67 edges in total.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_encrypt (
   input  logic         CLK,
   input  logic         RESET,
   aes_encrypt_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SUB   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_MIX   = 3'd3,
      ST_ARK   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [3:0] c_LAST_ROUND = 4'd10;

   // ---------------------------------------------------------------------
   // GF(2^8) helpers, reduction polynomial 0x11B
   // ---------------------------------------------------------------------
   function automatic logic [7:0] f_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] f_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = f_xtime(x);
      end
      return p;
   endfunction

   // S-box computed algebraically: multiplicative inverse (b^254, with 0->0)
   // followed by the FIPS-197 affine transform.
   function automatic logic [7:0] f_sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = f_gf_mul(sq, sq);
         inv = f_gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] f_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
              f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
   endfunction

   function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1B;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Registers and datapath wires
   // ---------------------------------------------------------------------
   state_t       r_state;
   state_t       w_state_next;
   logic [127:0] r_aes_state;
   logic [127:0] r_round_key;
   logic [127:0] r_msg_enc;
   logic [3:0]   r_round;
   logic [1:0]   r_col;

   logic [127:0] w_sub;
   logic [127:0] w_shift;
   logic [127:0] w_mix;
   logic [127:0] w_key_next;
   logic [127:0] w_ark;
   logic [31:0]  w_col_in;
   logic [31:0]  w_col_out;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub_word;
   logic [31:0]  w_temp;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;

   // SubBytes on all 16 state bytes
   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign w_sub[127-8*i -: 8] = f_sbox(r_aes_state[127-8*i -: 8]);
   end

   // ShiftRows: output byte (row r, col c) takes input (row r, col c+r mod 4)
   always_comb begin
      w_shift = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_shift[127-8*(4*c+r) -: 8] = r_aes_state[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end

   // Select the column addressed by the column counter for MixColumns
   always_comb begin
      w_col_in = r_aes_state[127:96];
      case (r_col)
         2'd0: w_col_in = r_aes_state[127:96];
         2'd1: w_col_in = r_aes_state[95:64];
         2'd2: w_col_in = r_aes_state[63:32];
         2'd3: w_col_in = r_aes_state[31:0];
         default: w_col_in = r_aes_state[127:96];
      endcase
   end

   assign w_col_out = f_mix_col(w_col_in);

   // Write the mixed column back into its slot, other columns untouched
   always_comb begin
      w_mix = r_aes_state;
      case (r_col)
         2'd0: w_mix[127:96] = w_col_out;
         2'd1: w_mix[95:64]  = w_col_out;
         2'd2: w_mix[63:32]  = w_col_out;
         2'd3: w_mix[31:0]   = w_col_out;
         default: w_mix = r_aes_state;
      endcase
   end

   // Next round key: RotWord/SubWord/Rcon on word 3, then the XOR chain
   assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_key_sbox
      assign w_sub_word[31-8*i -: 8] = f_sbox(w_rot[31-8*i -: 8]);
   end

   assign w_temp     = w_sub_word ^ {f_rcon(r_round), 24'h000000};
   assign w_k0       = r_round_key[127:96] ^ w_temp;
   assign w_k1       = r_round_key[95:64]  ^ w_k0;
   assign w_k2       = r_round_key[63:32]  ^ w_k1;
   assign w_k3       = r_round_key[31:0]   ^ w_k2;
   assign w_key_next = {w_k0, w_k1, w_k2, w_k3};
   assign w_ark      = r_aes_state ^ w_key_next;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   // State register; reset overrides any request
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state: dropping the request in any busy state aborts to IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  w_state_next = bus.AES_START ? ST_SUB : ST_IDLE;
         ST_SUB:   w_state_next = bus.AES_START ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: begin
            if (!bus.AES_START)             w_state_next = ST_IDLE;
            else if (r_round < c_LAST_ROUND) w_state_next = ST_MIX;
            else                            w_state_next = ST_ARK;
         end
         ST_MIX: begin
            if (!bus.AES_START)   w_state_next = ST_IDLE;
            else if (r_col == 2'd3) w_state_next = ST_ARK;
            else                  w_state_next = ST_MIX;
         end
         ST_ARK: begin
            if (!bus.AES_START)               w_state_next = ST_IDLE;
            else if (r_round == c_LAST_ROUND) w_state_next = ST_DONE;
            else                              w_state_next = ST_SUB;
         end
         ST_DONE:  w_state_next = bus.AES_START ? ST_DONE : ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Datapath registers; only advance while the request is held
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_aes_state <= '0;
         r_round_key <= '0;
         r_msg_enc   <= '0;
         r_round     <= 4'd0;
         r_col       <= 2'd0;
      end else if (bus.AES_START) begin
         case (r_state)
            ST_IDLE: begin
               r_aes_state <= bus.AES_MSG_DEC ^ bus.AES_KEY;
               r_round_key <= bus.AES_KEY;
               r_round     <= 4'd1;
               r_col       <= 2'd0;
            end
            ST_SUB:   r_aes_state <= w_sub;
            ST_SHIFT: r_aes_state <= w_shift;
            ST_MIX: begin
               r_aes_state <= w_mix;
               r_col       <= r_col + 2'd1;
            end
            ST_ARK: begin
               r_round_key <= w_key_next;
               r_aes_state <= w_ark;
               if (r_round == c_LAST_ROUND) r_msg_enc <= w_ark;
               else                         r_round   <= r_round + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.AES_DONE    = (r_state == ST_DONE);
   assign bus.AES_MSG_ENC = r_msg_enc;

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_aes_encrypt
//  Description : Self-checking bench for aes_encrypt using known AES-128
//                vectors, a ciphertext scoreboard and corner-case sequences
//                (reset, abort, input scrambling, mid-run reset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_encrypt;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   aes_encrypt_if bus ();

   aes_encrypt dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct packed {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t         r_vecs [4];
   logic [127:0] r_sb_q [$];
   logic [127:0] r_last_ct;
   int           r_errors = 0;
   int           r_checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      r_checks++;
      if (act !== exp) begin
         r_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Wait for completion, check latency and ciphertext, hold, then release
   task automatic wait_done(input string name, input bit scramble);
      int n;
      logic [127:0] exp;
      n = 0;
      while (n < 200) begin
         tick();
         n++;
         if (bus.AES_DONE) break;
         if (scramble) begin
            bus.AES_KEY     = {$urandom, $urandom, $urandom, $urandom};
            bus.AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check({name, " latency"}, 128'(n), 128'd67);
      exp = (r_sb_q.size() > 0) ? r_sb_q.pop_front() : 128'hx;
      check({name, " ciphertext"}, bus.AES_MSG_ENC, exp);
      for (int i = 0; i < 2; i++) begin
         tick();
         check({name, " done held"}, 128'(bus.AES_DONE), 128'd1);
      end
      check({name, " ct held"}, bus.AES_MSG_ENC, exp);
      bus.AES_START = 1'b0;
      tick();
      check({name, " done released"}, 128'(bus.AES_DONE), 128'd0);
      check({name, " ct after release"}, bus.AES_MSG_ENC, exp);
      r_last_ct = exp;
   endtask

   task automatic run_full(input string name, input vec_t v, input bit scramble);
      bus.AES_KEY     = v.key;
      bus.AES_MSG_DEC = v.pt;
      bus.AES_START   = 1'b1;
      r_sb_q.push_back(v.ct);
      wait_done(name, scramble);
   endtask

   // Test sequence
   initial begin
      r_vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      r_vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
      r_vecs[2] = '{key: 128'h00000000000000000000000000000000,
                    pt:  128'h00000000000000000000000000000000,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      r_vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a,
                    ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97};

      // Reset with request low, then with request high
      RESET           = 1'b1;
      bus.AES_START   = 1'b0;
      bus.AES_KEY     = r_vecs[0].key;
      bus.AES_MSG_DEC = r_vecs[0].pt;
      tick();
      tick();
      check("reset done start0", 128'(bus.AES_DONE), 128'd0);
      check("reset enc start0", bus.AES_MSG_ENC, 128'd0);
      bus.AES_START = 1'b1;
      tick();
      tick();
      check("reset done start1", 128'(bus.AES_DONE), 128'd0);
      check("reset enc start1", bus.AES_MSG_ENC, 128'd0);

      // Release reset with the request already high: first edge starts
      RESET = 1'b0;
      r_sb_q.push_back(r_vecs[0].ct);
      wait_done("fips_c1_after_reset", 1'b0);

      // Table of vectors, back-to-back with one idle cycle between
      for (int i = 0; i < 4; i++) begin
         run_full($sformatf("vec%0d", i), r_vecs[i], 1'b0);
      end

      // Key and plaintext scrambled every cycle after the sampling edge
      run_full("scramble", r_vecs[0], 1'b1);

      // Abort at edge 30
      bus.AES_KEY     = r_vecs[1].key;
      bus.AES_MSG_DEC = r_vecs[1].pt;
      bus.AES_START   = 1'b1;
      for (int i = 0; i < 29; i++) tick();
      check("abort done before", 128'(bus.AES_DONE), 128'd0);
      bus.AES_START = 1'b0;
      tick();
      check("abort done", 128'(bus.AES_DONE), 128'd0);
      check("abort enc kept", bus.AES_MSG_ENC, r_last_ct);
      for (int i = 0; i < 5; i++) tick();
      check("abort idle done", 128'(bus.AES_DONE), 128'd0);
      check("abort idle enc", bus.AES_MSG_ENC, r_last_ct);
      run_full("after_abort", r_vecs[2], 1'b0);

      // Reset at edge 40 with the request held high
      bus.AES_KEY     = r_vecs[3].key;
      bus.AES_MSG_DEC = r_vecs[3].pt;
      bus.AES_START   = 1'b1;
      for (int i = 0; i < 39; i++) tick();
      RESET = 1'b1;
      tick();
      check("midreset done", 128'(bus.AES_DONE), 128'd0);
      check("midreset enc", bus.AES_MSG_ENC, 128'd0);
      RESET = 1'b0;
      r_sb_q.push_back(r_vecs[3].ct);
      wait_done("after_midreset", 1'b0);

      check("scoreboard empty", 128'(r_sb_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
      $finish;
   end

endmodule
`default_nettype wire
